background_blitter: RTL

BACKGROUND_BLITTER -- requirements
Module: background_blitter

---
 rtl/background_blitter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/background_blitter.sv
// Copies a WIDTH x HEIGHT frame from a synchronous frame ROM to the vga_adapter in raster order.
// The fetch position runs one pixel ahead of the emit position; a one-entry skid buffer keeps them aligned across hold.
module background_blitter #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        hold,
  output logic [14:0] rom_addr,
  input  logic [2:0]  rom_q,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  // state  | meaning
  // IDLE   | waiting for start
  // PRIME  | address 0 on the ROM, covering its read latency
  // DRAW   | one pixel emitted per cycle unless hold; one tail cycle after the last pixel
  // FINISH | done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, PRIME, DRAW, FINISH} state_t;

  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_clear;
  logic        w_fetch_adv;
  logic        w_emit;
  logic        w_fetch_last;
  logic        w_emit_last;

  logic [7:0]  r_x_cnt;
  logic [6:0]  r_y_cnt;
  logic [14:0] r_addr;
  logic [7:0]  r_ex;
  logic [6:0]  r_ey;
  logic [2:0]  r_skid;
  logic        r_skid_vld;
  logic        r_tail;
  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic [2:0]  r_colour;
  logic        r_plot;

  assign w_fetch_last = (r_x_cnt == X_LAST) && (r_y_cnt == Y_LAST);
  assign w_emit_last  = (r_ex == X_LAST) && (r_ey == Y_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_fetch_adv = 1'b0;
    w_emit      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = PRIME;
          w_clear     = 1'b1;
        end
      end
      PRIME: begin
        w_state_nxt = DRAW;
        w_fetch_adv = 1'b1;
      end
      DRAW: begin
        if (r_tail) begin
          w_state_nxt = FINISH;
        end else if (!hold) begin
          w_emit      = 1'b1;
          w_fetch_adv = 1'b1;
        end
      end
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_x_cnt    <= '0;
      r_y_cnt    <= '0;
      r_addr     <= '0;
      r_ex       <= '0;
      r_ey       <= '0;
      r_skid     <= '0;
      r_skid_vld <= 1'b0;
      r_tail     <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_colour   <= '0;
      r_plot     <= 1'b0;
    end else begin
      r_plot <= w_emit;
      if (w_clear) begin
        r_x_cnt    <= '0;
        r_y_cnt    <= '0;
        r_addr     <= '0;
        r_ex       <= '0;
        r_ey       <= '0;
        r_skid_vld <= 1'b0;
        r_tail     <= 1'b0;
      end else if (w_fetch_adv && !w_fetch_last) begin
        r_addr <= r_addr + 15'd1;
        if (r_x_cnt == X_LAST) begin
          r_x_cnt <= '0;
          r_y_cnt <= r_y_cnt + 7'd1;
        end else begin
          r_x_cnt <= r_x_cnt + 8'd1;
        end
      end
      if (w_emit) begin
        r_x        <= r_ex;
        r_y        <= r_ey;
        r_colour   <= r_skid_vld ? r_skid : rom_q;
        r_skid_vld <= 1'b0;
        if (w_emit_last) begin
          r_tail <= 1'b1;
        end else if (r_ex == X_LAST) begin
          r_ex <= '0;
          r_ey <= r_ey + 7'd1;
        end else begin
          r_ex <= r_ex + 8'd1;
        end
      end else if (r_state == DRAW && !r_tail && !r_skid_vld) begin
        // First held cycle: ROM data still belongs to the pending pixel, keep it before the frozen address overwrites it.
        r_skid     <= rom_q;
        r_skid_vld <= 1'b1;
      end
    end
  end

  assign rom_addr = r_addr;
  assign x        = r_x;
  assign y        = r_y;
  assign colour   = r_colour;
  assign plot     = r_plot;
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == FINISH);

endmodule
